// File: rtl/keypad_lock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_lock_ctrl_pkg
// Description : Shared state encoding, key codes and display images for the
//               keypad lock controller and its dwell timer.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
    } lock_state_t;

    localparam logic [3:0]  KEY_STAR   = 4'hA;
    localparam logic [3:0]  KEY_HASH   = 4'hB;
    localparam logic [3:0]  NIB_BLANK  = 4'hF;

    localparam logic [23:0] DISP_BLANK = 24'hFFFFFF;
    localparam logic [23:0] DISP_ALARM = 24'hAAAAAA;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_lock_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : lock_dwell_timer
// Description : Tick counter with synchronous clear and terminal-count detect
//               against a selectable limit.
// Ports       : clk, rst (async active-low), clear, tick, limit -> expire
//               expire is high in the cycle whose tick completes `limit` ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_dwell_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [WIDTH-1:0] limit,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + WIDTH'(1);
        end
    end

    // Flag the tick that would bring the count up to the limit, so the owner
    // can leave its state on that same edge.
    assign expire = tick && !clear && (count == (limit - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_lock_ctrl
// Description : PIN entry sequencer. Collects DIGITS key digits, checks them
//               against CODE, drives unlock/alarm and owns the 6-nibble
//               display image.
// Ports       : clk, rst (async active-low), tick, key_valid, key_code[3:0]
//               -> display_code[23:0], unlock, alarm, fail_cnt[2:0], state[2:0]
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_lock_ctrl
    import keypad_lock_ctrl_pkg::*;
#(
    parameter int          DIGITS     = 4,
    parameter logic [23:0] CODE       = 24'h001234,
    parameter int          MAX_FAIL   = 3,
    parameter int          OPEN_TICKS = 64,
    parameter int          FAIL_TICKS = 16,
    parameter int          LOCK_TICKS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [23:0] display_code,
    output logic        unlock,
    output logic        alarm,
    output logic [2:0]  fail_cnt,
    output logic [2:0]  state
);

    localparam int MAX_T = (OPEN_TICKS > FAIL_TICKS)
                         ? ((OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS)
                         : ((FAIL_TICKS > LOCK_TICKS) ? FAIL_TICKS : LOCK_TICKS);
    localparam int TW    = $clog2(MAX_T) + 1;

    lock_state_t    cur_state;
    logic [2:0]     digit_cnt;
    logic [TW-1:0]  timer_limit;
    logic           timer_clear;
    logic           timer_expire;
    logic           code_match;
    logic [2:0]     fail_inc;

    // The timer is held clear outside the timed states; every timed state is
    // entered from CHECK, so the count always starts from zero on entry.
    always_comb begin
        timer_clear = !((cur_state == ST_OPEN) || (cur_state == ST_FAIL) ||
                        (cur_state == ST_LOCKOUT));
        case (cur_state)
            ST_OPEN: timer_limit = TW'(OPEN_TICKS);
            ST_FAIL: timer_limit = TW'(FAIL_TICKS);
            default: timer_limit = TW'(LOCK_TICKS);
        endcase
    end

    lock_dwell_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .tick   (tick),
        .limit  (timer_limit),
        .expire (timer_expire)
    );

    // The entered digits live in the low nibbles of the display image.
    assign code_match = (digit_cnt == 3'(DIGITS)) &&
                        (display_code[DIGITS*4-1:0] == CODE[DIGITS*4-1:0]);
    assign fail_inc   = (fail_cnt == 3'd7) ? 3'd7 : (fail_cnt + 3'd1);
    assign state      = cur_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state    <= ST_IDLE;
            display_code <= DISP_BLANK;
            unlock       <= 1'b0;
            alarm        <= 1'b0;
            fail_cnt     <= 3'd0;
            digit_cnt    <= 3'd0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (key_valid && is_digit(key_code)) begin
                        display_code <= {{5{NIB_BLANK}}, key_code};
                        digit_cnt    <= 3'd1;
                        cur_state    <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (key_valid) begin
                        if (is_digit(key_code)) begin
                            // Digits beyond the PIN length are dropped.
                            if (digit_cnt < 3'(DIGITS)) begin
                                display_code <= {display_code[19:0], key_code};
                                digit_cnt    <= digit_cnt + 3'd1;
                            end
                        end else if (key_code == KEY_STAR) begin
                            display_code <= DISP_BLANK;
                            digit_cnt    <= 3'd0;
                            cur_state    <= ST_IDLE;
                        end else if (key_code == KEY_HASH) begin
                            cur_state    <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    digit_cnt <= 3'd0;
                    if (code_match) begin
                        fail_cnt     <= 3'd0;
                        display_code <= DISP_BLANK;
                        unlock       <= 1'b1;
                        cur_state    <= ST_OPEN;
                    end else begin
                        fail_cnt <= fail_inc;
                        if (fail_inc >= 3'(MAX_FAIL)) begin
                            display_code <= DISP_ALARM;
                            alarm        <= 1'b1;
                            cur_state    <= ST_LOCKOUT;
                        end else begin
                            display_code <= {{5{NIB_BLANK}}, 1'b0, fail_inc};
                            cur_state    <= ST_FAIL;
                        end
                    end
                end
                ST_OPEN: begin
                    // A relock and an expiring tick lead to the same place.
                    if ((key_valid && (key_code == KEY_HASH)) || timer_expire) begin
                        unlock    <= 1'b0;
                        cur_state <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    if (timer_expire) begin
                        display_code <= DISP_BLANK;
                        cur_state    <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_expire) begin
                        fail_cnt     <= 3'd0;
                        display_code <= DISP_BLANK;
                        alarm        <= 1'b0;
                        cur_state    <= ST_IDLE;
                    end
                end
                default: begin
                    display_code <= DISP_BLANK;
                    unlock       <= 1'b0;
                    alarm        <= 1'b0;
                    digit_cnt    <= 3'd0;
                    cur_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
